reflex_judge: RTL and testbench

- Consumer end of the `clk_4s` round clock. It sits beside `counter_4s` and downstream of the button pins.
- Each toggle of `clk_4s` opens one response window. The block judges the player's button press against the lit target and tallies hits and errors.
- It drives `wrong_time` back to `counter_4s`, which halts the round clock at 3 errors. It also flags game over.

---
 rtl/reflex_judge.sv | 193 +++++++++++++++++++
 tb/tb_reflex_judge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reflex_judge.sv
// Reflex judge: scores button presses against the lit target, one response window per clk_4s edge.
// Latency: button pin to press_pulse 3 clk; hit/miss/score/wrong_time registered 1 clk after press_pulse or win_edge.
// Backpressure: none; switch=0 freezes all state and ignores presses and window edges.
//
// Ports: clk/rst (sync, active-high), switch (run/freeze), clk_4s (round clock, both edges open a window),
//        target (one-hot lit target), btn (raw async buttons), wrong_time/score/round_cnt (counters),
//        hit/miss (one-cycle pulses), game_over (level until rst).
// Optional macro REACTION_TIME_EN adds best_ms (fastest hit in TICK_DIV-cycle ticks).
module reflex_judge #(
    parameter int MAX_WRONG = 3,
    parameter int ROUNDS    = 15,
    parameter int TICK_DIV  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        switch,
    input  logic        clk_4s,
    input  logic [3:0]  target,
    input  logic [3:0]  btn,
    output logic [2:0]  wrong_time,
    output logic [4:0]  score,
    output logic [3:0]  round_cnt,
    output logic        hit,
    output logic        miss,
    output logic        game_over
`ifdef REACTION_TIME_EN
    ,
    output logic [15:0] best_ms
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, JUDGED, OVER} state_t;

    state_t     state_q;
    logic [3:0] tgt_q;
    logic [3:0] round_q;
    logic [4:0] score_q;
    logic [2:0] wrong_q;
    logic       hit_q, miss_q, over_q;

    // Button synchronizer, delay stage for edge detect, registered press pulse.
    logic [3:0] btn_s1_q, btn_s2_q, btn_s3_q, press_q;
    logic       clk4s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= 4'd0;
            btn_s2_q <= 4'd0;
            btn_s3_q <= 4'd0;
            press_q  <= 4'd0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            press_q  <= btn_s2_q & ~btn_s3_q;
        end
    end

    // Tracks clk_4s even through reset so a high level at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        clk4s_q <= clk_4s;
    end

    logic       win_edge;
    logic       press_any, press_ok, last_round, err_limit;
    logic [2:0] wrong_d;
    logic [4:0] score_d;

    assign win_edge   = clk_4s ^ clk4s_q;
    assign press_any  = |press_q;
    // Exactly one bit pressed and it equals the latched target.
    assign press_ok   = (press_q == tgt_q) && ((press_q & (press_q - 4'd1)) == 4'd0);
    assign last_round = (round_q == 4'(ROUNDS));
    assign wrong_d    = (wrong_q == 3'(MAX_WRONG)) ? wrong_q : wrong_q + 3'd1;
    assign err_limit  = (wrong_d == 3'(MAX_WRONG));
    assign score_d    = (score_q == 5'd31) ? score_q : score_q + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= 4'd0;
            round_q <= 4'd0;
            score_q <= 5'd0;
            wrong_q <= 3'd0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (switch) begin
                case (state_q)
                    IDLE: begin
                        if (win_edge) begin
                            tgt_q   <= target;
                            round_q <= 4'd1;
                            state_q <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (win_edge) begin
                            // Timeout; a press in the same cycle is discarded.
                            miss_q  <= 1'b1;
                            wrong_q <= wrong_d;
                            if (err_limit || last_round) begin
                                state_q <= OVER;
                                over_q  <= 1'b1;
                            end else begin
                                round_q <= round_q + 4'd1;
                                tgt_q   <= target;
                                state_q <= ARMED;
                            end
                        end else if (press_any) begin
                            if (press_ok) begin
                                hit_q   <= 1'b1;
                                score_q <= score_d;
                                state_q <= JUDGED;
                            end else begin
                                miss_q  <= 1'b1;
                                wrong_q <= wrong_d;
                                if (err_limit) begin
                                    state_q <= OVER;
                                    over_q  <= 1'b1;
                                end else begin
                                    state_q <= JUDGED;
                                end
                            end
                        end
                    end
                    JUDGED: begin
                        if (win_edge) begin
                            if (last_round) begin
                                state_q <= OVER;
                                over_q  <= 1'b1;
                            end else begin
                                round_q <= round_q + 4'd1;
                                tgt_q   <= target;
                                state_q <= ARMED;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wrong_time = wrong_q;
    assign score      = score_q;
    assign round_cnt  = round_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign game_over  = over_q;

`ifdef REACTION_TIME_EN
    localparam int PW = $clog2(TICK_DIV + 1);

    logic [PW-1:0] pre_q;
    logic [15:0]   tick_q, best_q;
    logic          open_win, hit_now;

    // Mirrors the FSM conditions that open a window or score a hit.
    assign open_win = switch && win_edge &&
                      ((state_q == IDLE) ||
                       (state_q == ARMED  && !err_limit && !last_round) ||
                       (state_q == JUDGED && !last_round));
    assign hit_now  = switch && !win_edge && (state_q == ARMED) && press_any && press_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 16'd0;
            best_q <= 16'hFFFF;
        end else if (switch) begin
            if (open_win) begin
                pre_q  <= '0;
                tick_q <= 16'd0;
            end else if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_q  <= '0;
                tick_q <= (tick_q == 16'hFFFF) ? tick_q : tick_q + 16'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            if (hit_now && (tick_q < best_q)) begin
                best_q <= tick_q;
            end
        end
    end

    assign best_ms = best_q;
`endif

endmodule

// File: tb/tb_reflex_judge.sv
// Testbench for reflex_judge: scoreboard of expected judgement pulses plus direct state checks.
// Latency: judgements compared whenever the DUT pulses hit or miss.
// Backpressure: none.
module tb_reflex_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       switch = 1'b0;
    logic       clk_4s = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] btn = 4'd0;
    logic [2:0] wrong_time;
    logic [4:0] score;
    logic [3:0] round_cnt;
    logic       hit, miss, game_over;
`ifdef REACTION_TIME_EN
    logic [15:0] best_ms;
`endif

    reflex_judge dut (
        .clk        (clk),
        .rst        (rst),
        .switch     (switch),
        .clk_4s     (clk_4s),
        .target     (target),
        .btn        (btn),
        .wrong_time (wrong_time),
        .score      (score),
        .round_cnt  (round_cnt),
        .hit        (hit),
        .miss       (miss),
        .game_over  (game_over)
`ifdef REACTION_TIME_EN
        ,
        .best_ms    (best_ms)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       h;
        logic       m;
        logic [4:0] sc;
        logic [2:0] wr;
        logic [3:0] rd;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic h, input logic m, input int sc, input int wr, input int rd,
                        input logic ov);
        exp_t e;
        e.h = h; e.m = m; e.sc = 5'(sc); e.wr = 3'(wr); e.rd = 4'(rd); e.ov = ov;
        sb.push_back(e);
    endtask

    // Every hit/miss pulse is matched against the oldest expected judgement.
    always @(negedge clk) begin
        if (!rst && (hit || miss)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_hit", hit, e.h);
                chk("pulse_miss", miss, e.m);
                chk("pulse_score", score, e.sc);
                chk("pulse_wrong", wrong_time, e.wr);
                chk("pulse_round", round_cnt, e.rd);
                chk("pulse_over", game_over, e.ov);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle(input logic [3:0] t);
        target = t;
        clk_4s = ~clk_4s;
        tick(4);
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick(6);
        btn = 4'd0;
        tick(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        sb.delete();
        chk("rst_wrong", wrong_time, 0);
        chk("rst_score", score, 0);
        chk("rst_round", round_cnt, 0);
        chk("rst_over", game_over, 0);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic state_chk(input string tag, input int sc, input int wr, input int rd, input logic ov);
        chk({tag, "_score"}, score, sc);
        chk({tag, "_wrong"}, wrong_time, wr);
        chk({tag, "_round"}, round_cnt, rd);
        chk({tag, "_over"}, game_over, ov);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic [3:0] t;
        switch = 1'b1;
        tick(1);
        do_reset();
`ifdef REACTION_TIME_EN
        chk("best_rst", best_ms, 16'hFFFF);
`endif
        // Basic hit 1000 cycles into the first window.
        toggle(4'b0010);
        tick(1000);
        push(1, 0, 1, 0, 1, 0);
        press(4'b0010);
        drained("hit1");
`ifdef REACTION_TIME_EN
        chk("best_hit", best_ms, 0);
`endif
        // Wrong button, then a second press in the same window is ignored.
        toggle(4'b0100);
        push(0, 1, 1, 1, 2, 0);
        press(4'b0001);
        press(4'b0100);
        drained("wrong1");
        state_chk("second_press", 1, 1, 2, 0);

        // Three timeouts end the game; later activity changes nothing.
        do_reset();
        toggle(4'b0001);
        push(0, 1, 0, 1, 2, 0);
        toggle(4'b0001);
        tick(10);
        push(0, 1, 0, 2, 3, 0);
        toggle(4'b0010);
        tick(10);
        push(0, 1, 0, 3, 3, 1);
        toggle(4'b0100);
        drained("timeouts");
        state_chk("err_over", 0, 3, 3, 1);
        toggle(4'b1000);
        press(4'b1000);
        toggle(4'b0001);
        state_chk("after_over", 0, 3, 3, 1);

        // Fifteen hit windows, then the sixteenth edge ends the game.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            t = 4'b0001 << (i % 4);
            toggle(t);
            push(1, 0, i, 0, i, 0);
            press(t);
        end
        drained("rounds");
        state_chk("pre_final", 15, 0, 15, 0);
        toggle(4'b0001);
        state_chk("final", 15, 0, 15, 1);

        // Press pulse coinciding with the window edge is discarded; timeout counts.
        do_reset();
        toggle(4'b0001);
        tick(10);
        btn = 4'b0001;
        tick(3);
        push(0, 1, 0, 1, 2, 0);
        clk_4s = ~clk_4s;
        tick(6);
        btn = 4'd0;
        tick(6);
        drained("coincide");
        // Multiple bits pressed is a miss.
        push(0, 1, 0, 2, 2, 0);
        press(4'b0011);
        drained("multi");

        // Freeze: a press while switch=0 is ignored and nothing moves.
        do_reset();
        toggle(4'b1000);
        switch = 1'b0;
        tick(20);
        press(4'b1000);
        tick(10000);
        state_chk("frozen", 0, 0, 1, 0);
        switch = 1'b1;
        tick(5);
        state_chk("thawed", 0, 0, 1, 0);
        push(1, 0, 1, 0, 1, 0);
        press(4'b1000);
        drained("after_freeze");

        // Mid-game reset clears everything on the next cycle.
        rst = 1'b1;
        tick(1);
        state_chk("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick(2);
        toggle(4'b0100);
        state_chk("rst_idle", 0, 0, 1, 0);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
